port_afu_rst_seq: RTL

Per-port soft-reset sequencer for the port gasket, scaled to any number of AFU ports. For each port it tracks outstanding host read requests and gates new AFU TX traffic on a reset request. It waits for in-flight completions to drain, with a timeout, then drives that port's `port_rst_n` low for a fixed hold time before releasing it. It sits between the port CSR soft-reset bits and the `port_rst_n` vector consumed by `port_afu_instances`.

---
 rtl/port_afu_rst_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/port_afu_rst_seq.sv
// Per-port soft-reset sequencer: gates AFU TX, drains outstanding reads (with timeout),
// then holds port_rst_n low for a fixed time before releasing it.
module port_afu_rst_seq #(
    parameter int NUM_PORTS       = 1,
    parameter int CNT_W           = 10,
    parameter int RST_HOLD_CYCLES = 16,
    parameter int TIMEOUT_W       = 16,
    parameter int DRAIN_TIMEOUT   = 65535
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_PORTS-1:0]       soft_rst_req,
    input  logic [NUM_PORTS-1:0]       rd_issued,
    input  logic [NUM_PORTS-1:0]       rd_cpl_last,
    output logic [NUM_PORTS-1:0]       tx_gate,
    output logic [NUM_PORTS-1:0]       port_rst_n,
    output logic [NUM_PORTS-1:0]       rst_ack,
    output logic [NUM_PORTS-1:0]       drain_timeout,
    output logic [NUM_PORTS*CNT_W-1:0] outstanding
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_HOLD     = 2'd2,
        ST_REL_WAIT = 2'd3
    } state_e;

    localparam int HOLD_W = $clog2(RST_HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TMR_MAX   = TIMEOUT_W'(DRAIN_TIMEOUT);
    localparam logic [CNT_W-1:0]     CNT_MAX   = {CNT_W{1'b1}};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        state_e               state_q, state_d;
        logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_step;
        logic [TIMEOUT_W-1:0] tmr_q, tmr_d;
        logic [HOLD_W-1:0]    hold_q, hold_d;
        logic                 to_q, to_d;
        logic                 gate_q, gate_d;
        logic                 prst_n_q, prst_n_d;
        logic                 ack_q, ack_d;

        // Saturating outstanding-read count update; simultaneous issue+completion cancels.
        always_comb begin
            cnt_step = cnt_q;
            if (rd_issued[p] && !rd_cpl_last[p]) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_step = cnt_q + CNT_W'(1);
                end else begin
                    cnt_step = cnt_q;
                end
            end else if (rd_cpl_last[p] && !rd_issued[p]) begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_step = cnt_q - CNT_W'(1);
                end else begin
                    cnt_step = cnt_q;
                end
            end else begin
                cnt_step = cnt_q;
            end
        end

        // Next-state, counters and output decode of the next state.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            tmr_d   = tmr_q;
            hold_d  = hold_q;
            to_d    = to_q;
            case (state_q)
                ST_IDLE: begin
                    cnt_d = cnt_step;
                    if (soft_rst_req[p]) begin
                        state_d = ST_DRAIN;
                        tmr_d   = {TIMEOUT_W{1'b0}};
                        to_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    // Exit decision uses the registered count; the flag marks a forced exit.
                    if ((cnt_q == {CNT_W{1'b0}}) || (tmr_q == TMR_MAX)) begin
                        state_d = ST_HOLD;
                        hold_d  = {HOLD_W{1'b0}};
                        cnt_d   = {CNT_W{1'b0}};
                        if (cnt_q != {CNT_W{1'b0}}) begin
                            to_d = 1'b1;
                        end else begin
                            to_d = to_q;
                        end
                    end else begin
                        cnt_d = cnt_step;
                        tmr_d = tmr_q + TIMEOUT_W'(1);
                    end
                end
                ST_HOLD: begin
                    cnt_d = {CNT_W{1'b0}};
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_REL_WAIT;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                ST_REL_WAIT: begin
                    cnt_d = {CNT_W{1'b0}};
                    if (!soft_rst_req[p]) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_REL_WAIT;
                    end
                end
                default: begin
                    state_d = ST_HOLD;
                    hold_d  = {HOLD_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
            gate_d   = (state_d != ST_IDLE);
            prst_n_d = (state_d == ST_IDLE) || (state_d == ST_DRAIN);
            ack_d    = (state_d == ST_HOLD) || (state_d == ST_REL_WAIT);
        end

        // State and output registers; reset lands every port in a fresh HOLD.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q  <= ST_HOLD;
                cnt_q    <= {CNT_W{1'b0}};
                tmr_q    <= {TIMEOUT_W{1'b0}};
                hold_q   <= {HOLD_W{1'b0}};
                to_q     <= 1'b0;
                gate_q   <= 1'b1;
                prst_n_q <= 1'b0;
                ack_q    <= 1'b1;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                tmr_q    <= tmr_d;
                hold_q   <= hold_d;
                to_q     <= to_d;
                gate_q   <= gate_d;
                prst_n_q <= prst_n_d;
                ack_q    <= ack_d;
            end
        end

        assign tx_gate[p]                    = gate_q;
        assign port_rst_n[p]                 = prst_n_q;
        assign rst_ack[p]                    = ack_q;
        assign drain_timeout[p]              = to_q;
        assign outstanding[p*CNT_W +: CNT_W] = cnt_q;
    end

endmodule
